// File: rtl/memory_256x8.sv
// memory_256x8: 256 x 8 unified program/data memory for the 8-bit CPU.
// One shared address bus. Reads are combinational and writes are synchronous.
// The boot program sits at 0x00-0x0F. A synchronous reset reloads the whole array.
module memory_256x8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] d_i,
    output logic [7:0] d_o
);

    typedef logic [7:0] mem_t [256];

    // Boot program bytes for addresses 0x00-0x0F.
    localparam logic [7:0] BOOT_IMAGE [16] = '{
        8'h6C, 8'h10, 8'h9C, 8'h58,
        8'h34, 8'hB6, 8'h66, 8'h76,
        8'h48, 8'h34, 8'hDC, 8'h14,
        8'hFF, 8'h03, 8'h10, 8'h00
    };

    // Builds the full 256-byte image: the boot program followed by zeros.
    // This image is both the power-up contents and the reset contents,
    // so the two can never drift apart.
    function automatic mem_t boot_contents();
        mem_t contents;
        for (int i = 0; i < 256; i++) begin
            if (i < 16) begin
                contents[i] = BOOT_IMAGE[i[3:0]];
            end else begin
                contents[i] = 8'h00;
            end
        end
        return contents;
    endfunction

    // The array holds the boot image from time zero, so no reset pulse is needed.
    mem_t mem = boot_contents();

    // Reset reloads the whole image and has priority over any write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= boot_contents();
        end else if (we) begin
            mem[addr] <= d_i;
        end
    end

    // Read is asynchronous with zero latency. A write becomes visible only after the edge.
    assign d_o = mem[addr];

endmodule

// File: tb/tb_memory_256x8.sv
// tb_memory_256x8: directed and randomized checks of memory_256x8.
// The expected values come from a plain array model of the memory.
module tb_memory_256x8;

    logic       clk;
    logic       rst;
    logic       we;
    logic [7:0] addr;
    logic [7:0] d_i;
    logic [7:0] d_o;

    int total;
    int bad;

    logic [7:0] ref_mem [256];
    logic [7:0] image [16];

    memory_256x8 dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .addr (addr),
        .d_i  (d_i),
        .d_o  (d_o)
    );

    // The clock period is 10 ns. Rising edges occur at 5, 15, 25 ns and so on.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Puts the model back to the boot image.
    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = (i < 16) ? image[i] : 8'h00;
        end
    endtask

    // Compares d_o with the expected value and counts any mismatch.
    task automatic check_output(input string tag, input logic [7:0] expected);
        total++;
        assert (d_o === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%02h expected=%02h (addr=%02h)", tag, d_o, expected, addr);
        end
    endtask

    // Drives a single write that spans one rising edge and updates the model.
    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a;
        d_i  = d;
        we   = 1'b1;
        @(posedge clk);
        ref_mem[a] = d;
        #1;
        we = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        image = '{8'h6C, 8'h10, 8'h9C, 8'h58, 8'h34, 8'hB6, 8'h66, 8'h76,
                  8'h48, 8'h34, 8'hDC, 8'h14, 8'hFF, 8'h03, 8'h10, 8'h00};
        model_reset();
        rst  = 1'b0;
        we   = 1'b0;
        addr = 8'h00;
        d_i  = 8'h00;

        // Step 1: read back the power-up image without any reset.
        #1;
        check_output("powerup_00", 8'h6C);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            addr = i[7:0];
            #1;
            check_output("image_read", image[i]);
        end
        @(negedge clk); addr = 8'h10; #1; check_output("zero_10", 8'h00);
        @(negedge clk); addr = 8'hFF; #1; check_output("zero_ff", 8'h00);

        // Step 2: write one byte, then confirm its neighbour is untouched.
        apply_stimulus(8'h20, 8'hA5);
        addr = 8'h20; #1; check_output("write_20", 8'hA5);
        addr = 8'h21; #1; check_output("neighbour_21", 8'h00);

        // Step 3: overwrite the image and write both boundary addresses.
        apply_stimulus(8'h00, 8'h5A);
        addr = 8'h00; #1; check_output("write_00", 8'h5A);
        apply_stimulus(8'hFF, 8'hC3);
        addr = 8'hFF; #1; check_output("write_ff", 8'hC3);
        addr = 8'h01; #1; check_output("keep_01", 8'h10);

        // Step 4: read during write. The old value shows before the edge and the new value after it.
        @(negedge clk);
        addr = 8'h03;
        d_i  = 8'hEE;
        we   = 1'b1;
        #1;
        check_output("rdw_before", 8'h58);
        @(posedge clk);
        ref_mem[8'h03] = 8'hEE;
        #1;
        check_output("rdw_after", 8'hEE);
        we = 1'b0;

        // Step 5: reset while a write is pending. The write must be discarded.
        @(negedge clk);
        rst  = 1'b1;
        we   = 1'b1;
        d_i  = 8'h77;
        addr = 8'h03;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        we  = 1'b0;
        check_output("rst_03", 8'h58);
        addr = 8'h00; #1; check_output("rst_00", 8'h6C);
        addr = 8'h20; #1; check_output("rst_20", 8'h00);
        addr = 8'hFF; #1; check_output("rst_ff", 8'h00);

        // Step 6: the read path follows addr with no clock edge in between.
        @(negedge clk);
        addr = 8'h0C; #1; check_output("comb_0c", 8'hFF);
        addr = 8'h0D; #1; check_output("comb_0d", 8'h03);

        // Randomized mix of reads, writes and resets, checked against the model.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 29) == 0);
            we   = $urandom_range(0, 1);
            addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            d_i  = 8'($urandom);
            #1;
            check_output("rand_before", ref_mem[addr]);
            @(posedge clk);
            if (rst) begin
                model_reset();
            end else if (we) begin
                ref_mem[addr] = d_i;
            end
            #1;
            check_output("rand_after", ref_mem[addr]);
            rst = 1'b0;
            we  = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_256x8.md
Name: memory_256x8

Overview:
- 256-word x 8-bit unified program/data memory for the 8-bit CPU.
- Single-port: combinational read, synchronous write.
- Holds a built-in 16-byte boot program image at addresses 0x00-0x0F; all other locations are zero.
- Serves instruction fetch and load/store from one address bus.

Parameters:
- None. Geometry is fixed at 256 x 8, and the boot image is hard-coded.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset; reloads boot image
- we   input  1  write enable; 1 = write d_i to mem[addr] on rising clk
- addr input  8  word address 0x00-0xFF, used for both read and write
- d_i  input  8  write data
- d_o  output 8  read data, always mem[addr]

Behaviour:
- Storage: 256 x 8-bit array, no address decoding gaps. Every 8-bit address is valid; no wrap or out-of-range case exists.
- Boot image, hex, addr:data:
  - 00:6C 01:10 02:9C 03:58
  - 04:34 05:B6 06:66 07:76
  - 08:48 09:34 0A:DC 0B:14
  - 0C:FF 0D:03 0E:10 0F:00
  - 10-FF: 00
- Power-up: the array already holds the boot image at time zero, without any reset pulse. This is done by simulation initialisation or FPGA init values.
- Read path:
  - d_o = mem[addr], purely combinational, zero clock latency.
  - d_o follows addr changes within the same cycle.
  - d_o never depends on we or d_i directly.
- Write path:
  - On rising clk with rst=0 and we=1: mem[addr] <= d_i.
  - With we=0, contents are unchanged.
- Read-during-write:
  - Before the edge, d_o shows old mem[addr].
  - After the edge, d_o shows the newly written d_i (write-first visibility from the next delta onward).
  - No bypass of d_i to d_o before the edge.
- Reset:
  - On rising clk with rst=1, all 256 locations are restored to the boot image in one cycle.
  - rst has priority over we; a write in a reset cycle is discarded.
  - After reset, d_o = image[addr] immediately.
  - Reset asserted mid-program discards all prior writes.
- X-handling:
  - we=X or addr=X in simulation need not be handled specially.
  - The bench must drive known values.
- Output reset value: d_o has no register. After reset it equals the image byte at the current addr, e.g. 0x6C at addr 0x00.

Test Plan:
1. Image readback, no reset, we=0: step addr 0x00..0x0F, one per 10 ns clock period, checking each before the next change → d_o = 6C,10,9C,58,34,B6,66,76,48,34,DC,14,FF,03,10,00. Then addr 0x10 and 0xFF → 00.
2. Write/read: we=1, addr=0x20, d_i=0xA5 for one rising edge, then we=0 → d_o=A5 at addr 0x20. addr 0x21 → 00, confirming no neighbour corruption.
3. Overwrite image and boundary addresses:
   - Write 0x5A to addr 0x00 → d_o=5A.
   - Write 0xC3 to 0xFF → d_o=C3 at 0xFF.
   - addr 0x01 → still 10.
4. Read-during-write timing: addr=0x03, d_i=0xEE, we=1.
   - Sample before the edge → 58.
   - Sample after the edge → EE.
5. Reset restore: after tests 2-4, pulse rst=1 for one edge with we=1, d_i=0x77, addr=0x03.
   - Afterwards, addr 0x00→6C, 0x03→58, 0x20→00, 0xFF→00. The concurrent write is ignored.
6. Combinational read: with clk held static, change addr 0x0C→0x0D → d_o changes FF→03 within the same cycle, without any clock edge.
